// File: rtl/pc_gen_btb_if.sv
// pc_gen_btb_if: fetch-PC generator bus (redirects, BTB training, PC out)
// master = pipeline side driving requests; slave = PC generator
interface pc_gen_btb_if #(
  parameter int XLEN = 32
);
  logic            en;
  logic            trap_valid;
  logic [XLEN-1:0] trap_target;
  logic            RedirectE;
  logic [XLEN-1:0] RedirectTargetE;
  logic            JalD;
  logic [XLEN-1:0] JalTarget;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic [XLEN-1:0] PC_Out;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;

  modport master (
    output en,
    output trap_valid,
    output trap_target,
    output RedirectE,
    output RedirectTargetE,
    output JalD,
    output JalTarget,
    output upd_valid,
    output upd_pc,
    output upd_taken,
    output upd_target,
    input  PC_Out,
    input  pred_taken,
    input  pred_target
  );

  modport slave (
    input  en,
    input  trap_valid,
    input  trap_target,
    input  RedirectE,
    input  RedirectTargetE,
    input  JalD,
    input  JalTarget,
    input  upd_valid,
    input  upd_pc,
    input  upd_taken,
    input  upd_target,
    output PC_Out,
    output pred_taken,
    output pred_target
  );
endinterface

// File: rtl/pc_gen_btb.sv
// pc_gen_btb: fetch PC register + direct-mapped BTB with 2-bit counters.
// Ports: clk, clear (async active-high), bus (pc_gen_btb_if.slave).
module pc_gen_btb #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              BTB_ENTRIES  = 16
) (
  input  logic         clk,
  input  logic         clear,
  pc_gen_btb_if.slave  bus
);

  localparam int IDX = $clog2(BTB_ENTRIES);
  localparam int TW  = XLEN - IDX - 2;

  logic [XLEN-1:0] r_pc;

  logic            r_valid  [BTB_ENTRIES];
  logic [TW-1:0]   r_tag    [BTB_ENTRIES];
  logic [XLEN-1:0] r_target [BTB_ENTRIES];
  logic [1:0]      r_ctr    [BTB_ENTRIES];

  // lookup side
  logic [IDX-1:0]  w_lidx;
  logic [TW-1:0]   w_ltag;
  logic            w_lhit;
  logic            w_pred;
  logic [XLEN-1:0] w_ptgt;

  // training side
  logic [IDX-1:0]  w_uidx;
  logic [TW-1:0]   w_utag;
  logic            w_uhit;
  logic [1:0]      w_ucur;
  logic [1:0]      w_unxt;

  logic [XLEN-1:0] w_seq;
  logic [XLEN-1:0] w_npc;
  logic [3:0]      w_unused_bits;

  assign w_unused_bits = {bus.upd_pc[1:0], r_pc[1:0]};

  assign w_lidx = r_pc[IDX+1:2];
  assign w_ltag = r_pc[XLEN-1:IDX+2];
  assign w_lhit = r_valid[w_lidx] && (r_tag[w_lidx] == w_ltag);
  assign w_pred = w_lhit && r_ctr[w_lidx][1];
  assign w_ptgt = w_pred ? r_target[w_lidx] : '0;

  assign bus.PC_Out      = r_pc;
  assign bus.pred_taken  = w_pred;
  assign bus.pred_target = w_ptgt;

  assign w_uidx = bus.upd_pc[IDX+1:2];
  assign w_utag = bus.upd_pc[XLEN-1:IDX+2];
  assign w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
  assign w_ucur = r_ctr[w_uidx];

  // saturating counter step
  always_comb begin
    w_unxt = w_ucur;
    if (bus.upd_taken) begin
      if (w_ucur != 2'b11) w_unxt = w_ucur + 2'b01;
    end else begin
      if (w_ucur != 2'b00) w_unxt = w_ucur - 2'b01;
    end
  end

  assign w_seq = r_pc + XLEN'(4);

  // trap bypasses the stall; everything else obeys en
  always_comb begin
    w_npc = r_pc;
    if (bus.trap_valid)      w_npc = bus.trap_target;
    else if (!bus.en)        w_npc = r_pc;
    else if (bus.RedirectE)  w_npc = bus.RedirectTargetE;
    else if (bus.JalD)       w_npc = bus.JalTarget;
    else if (w_pred)         w_npc = w_ptgt;
    else                     w_npc = w_seq;
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) r_pc <= RESET_VECTOR;
    else       r_pc <= w_npc;
  end

  // training ignores en and redirects; lookup this cycle sees old data
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b01;
      end
    end else if (bus.upd_valid) begin
      if (w_uhit) begin
        r_ctr[w_uidx] <= w_unxt;
        if (bus.upd_taken)
          r_target[w_uidx] <= bus.upd_target;
      end else if (bus.upd_taken) begin
        r_valid[w_uidx]  <= 1'b1;
        r_tag[w_uidx]    <= w_utag;
        r_target[w_uidx] <= bus.upd_target;
        r_ctr[w_uidx]    <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_pc_gen_btb.sv
// tb_pc_gen_btb: directed checks of PC selection, BTB and reset.
// Two instances: reset vector 0 and 0xFFFF_FFF8 (wrap).
module tb_pc_gen_btb;

  logic clk;
  logic clear0;
  logic clear1;
  int   checks;
  int   failures;

  pc_gen_btb_if #(.XLEN(32)) b0 ();
  pc_gen_btb_if #(.XLEN(32)) b1 ();

  pc_gen_btb #(
    .XLEN(32),
    .RESET_VECTOR(32'h0000_0000),
    .BTB_ENTRIES(16)
  ) dut0 (
    .clk(clk),
    .clear(clear0),
    .bus(b0)
  );

  pc_gen_btb #(
    .XLEN(32),
    .RESET_VECTOR(32'hFFFF_FFF8),
    .BTB_ENTRIES(16)
  ) dut1 (
    .clk(clk),
    .clear(clear1),
    .bus(b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle0();
    b0.en = 1'b1;
    b0.trap_valid = 1'b0;
    b0.trap_target = '0;
    b0.RedirectE = 1'b0;
    b0.RedirectTargetE = '0;
    b0.JalD = 1'b0;
    b0.JalTarget = '0;
    b0.upd_valid = 1'b0;
    b0.upd_pc = '0;
    b0.upd_taken = 1'b0;
    b0.upd_target = '0;
  endtask

  task automatic redirect0(input logic [31:0] t);
    b0.RedirectE = 1'b1;
    b0.RedirectTargetE = t;
    tick();
    b0.RedirectE = 1'b0;
  endtask

  task automatic test_reset();
    clear0 = 1'b1;
    idle0();
    #3;
    checks++;
    if (b0.PC_Out !== 32'h0) begin
      failures++;
      $display("FAIL rst_pc got=%h exp=%h", b0.PC_Out, 32'h0);
    end
    checks++;
    if (b0.pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL rst_pred got=%b exp=0", b0.pred_taken);
    end
    tick();
    tick();
    checks++;
    if (b0.PC_Out !== 32'h0) begin
      failures++;
      $display("FAIL rst_hold got=%h exp=%h", b0.PC_Out, 32'h0);
    end
    clear0 = 1'b0;
    tick();
    checks++;
    if (b0.PC_Out !== 32'h4) begin
      failures++;
      $display("FAIL rst_seq1 got=%h exp=%h", b0.PC_Out, 32'h4);
    end
    tick();
    checks++;
    if (b0.PC_Out !== 32'h8) begin
      failures++;
      $display("FAIL rst_seq2 got=%h exp=%h", b0.PC_Out, 32'h8);
    end
  endtask

  task automatic test_wrap();
    b1.en = 1'b1;
    b1.trap_valid = 1'b0;
    b1.trap_target = '0;
    b1.RedirectE = 1'b0;
    b1.RedirectTargetE = '0;
    b1.JalD = 1'b0;
    b1.JalTarget = '0;
    b1.upd_valid = 1'b0;
    b1.upd_pc = '0;
    b1.upd_taken = 1'b0;
    b1.upd_target = '0;
    clear1 = 1'b1;
    #1;
    checks++;
    if (b1.PC_Out !== 32'hFFFF_FFF8) begin
      failures++;
      $display("FAIL wrap_rst got=%h exp=%h", b1.PC_Out, 32'hFFFF_FFF8);
    end
    tick();
    clear1 = 1'b0;
    tick();
    checks++;
    if (b1.PC_Out !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_1 got=%h exp=%h", b1.PC_Out, 32'hFFFF_FFFC);
    end
    tick();
    checks++;
    if (b1.PC_Out !== 32'h0) begin
      failures++;
      $display("FAIL wrap_2 got=%h exp=%h", b1.PC_Out, 32'h0);
    end
    clear1 = 1'b1;
  endtask

  task automatic test_priority();
    b0.trap_valid = 1'b1;
    b0.trap_target = 32'h100;
    b0.RedirectE = 1'b1;
    b0.RedirectTargetE = 32'h200;
    b0.JalD = 1'b1;
    b0.JalTarget = 32'h300;
    b0.en = 1'b0;
    tick();
    checks++;
    if (b0.PC_Out !== 32'h100) begin
      failures++;
      $display("FAIL prio_trap got=%h exp=%h", b0.PC_Out, 32'h100);
    end
    b0.trap_valid = 1'b0;
    b0.en = 1'b1;
    tick();
    checks++;
    if (b0.PC_Out !== 32'h200) begin
      failures++;
      $display("FAIL prio_redir got=%h exp=%h", b0.PC_Out, 32'h200);
    end
    b0.RedirectE = 1'b0;
    tick();
    checks++;
    if (b0.PC_Out !== 32'h300) begin
      failures++;
      $display("FAIL prio_jal got=%h exp=%h", b0.PC_Out, 32'h300);
    end
    idle0();
    tick();
    checks++;
    if (b0.PC_Out !== 32'h304) begin
      failures++;
      $display("FAIL prio_seq got=%h exp=%h", b0.PC_Out, 32'h304);
    end
  endtask

  task automatic test_btb();
    // allocate 0x10 -> 0x80 while redirecting fetch to 0x10
    b0.upd_valid = 1'b1;
    b0.upd_pc = 32'h10;
    b0.upd_taken = 1'b1;
    b0.upd_target = 32'h80;
    redirect0(32'h10);
    b0.upd_valid = 1'b0;
    checks++;
    if (b0.pred_taken !== 1'b1) begin
      failures++;
      $display("FAIL btb_alloc_pred got=%b exp=1", b0.pred_taken);
    end
    checks++;
    if (b0.pred_target !== 32'h80) begin
      failures++;
      $display("FAIL btb_alloc_tgt got=%h exp=%h", b0.pred_target, 32'h80);
    end
    tick();
    checks++;
    if (b0.PC_Out !== 32'h80) begin
      failures++;
      $display("FAIL btb_follow got=%h exp=%h", b0.PC_Out, 32'h80);
    end
    // not-taken: ctr 10 -> 01
    b0.upd_valid = 1'b1;
    b0.upd_taken = 1'b0;
    tick();
    b0.upd_valid = 1'b0;
    redirect0(32'h10);
    checks++;
    if (b0.pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL btb_nt_pred got=%b exp=0", b0.pred_taken);
    end
    checks++;
    if (b0.pred_target !== 32'h0) begin
      failures++;
      $display("FAIL btb_nt_tgt got=%h exp=%h", b0.pred_target, 32'h0);
    end
    // same-cycle train while fetching 0x10: old view used
    b0.upd_valid = 1'b1;
    b0.upd_taken = 1'b1;
    b0.upd_target = 32'h90;
    tick();
    b0.upd_valid = 1'b0;
    checks++;
    if (b0.PC_Out !== 32'h14) begin
      failures++;
      $display("FAIL btb_nt_seq got=%h exp=%h", b0.PC_Out, 32'h14);
    end
    redirect0(32'h10);
    checks++;
    if (b0.pred_target !== 32'h90) begin
      failures++;
      $display("FAIL btb_retgt got=%h exp=%h", b0.pred_target, 32'h90);
    end
  endtask

  task automatic test_alias();
    redirect0(32'h50);
    checks++;
    if (b0.pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL alias_pred got=%b exp=0", b0.pred_taken);
    end
    tick();
    checks++;
    if (b0.PC_Out !== 32'h54) begin
      failures++;
      $display("FAIL alias_seq got=%h exp=%h", b0.PC_Out, 32'h54);
    end
  endtask

  task automatic test_stall();
    redirect0(32'h20);
    b0.en = 1'b0;
    b0.RedirectE = 1'b1;
    b0.RedirectTargetE = 32'h400;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (b0.PC_Out !== 32'h20) begin
        failures++;
        $display("FAIL stall_%0d got=%h exp=%h", i, b0.PC_Out, 32'h20);
      end
    end
    b0.RedirectE = 1'b0;
    b0.upd_valid = 1'b1;
    b0.upd_pc = 32'h20;
    b0.upd_taken = 1'b1;
    b0.upd_target = 32'h60;
    tick();
    b0.upd_valid = 1'b0;
    checks++;
    if (b0.pred_taken !== 1'b1 || b0.PC_Out !== 32'h20) begin
      failures++;
      $display("FAIL stall_train got=%b/%h exp=1/%h",
               b0.pred_taken, b0.PC_Out, 32'h20);
    end
    b0.trap_valid = 1'b1;
    b0.trap_target = 32'h200;
    tick();
    idle0();
    checks++;
    if (b0.PC_Out !== 32'h200) begin
      failures++;
      $display("FAIL stall_trap got=%h exp=%h", b0.PC_Out, 32'h200);
    end
  endtask

  task automatic test_reset_midrun();
    b0.upd_valid = 1'b1;
    b0.upd_pc = 32'h40;
    b0.upd_taken = 1'b1;
    b0.upd_target = 32'hC0;
    redirect0(32'h40);
    idle0();
    checks++;
    if (b0.pred_taken !== 1'b1 || b0.PC_Out !== 32'h40) begin
      failures++;
      $display("FAIL mid_pre got=%b/%h exp=1/%h",
               b0.pred_taken, b0.PC_Out, 32'h40);
    end
    #2;
    clear0 = 1'b1;
    #1;
    checks++;
    if (b0.PC_Out !== 32'h0) begin
      failures++;
      $display("FAIL mid_pc got=%h exp=%h", b0.PC_Out, 32'h0);
    end
    checks++;
    if (b0.pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL mid_pred got=%b exp=0", b0.pred_taken);
    end
    tick();
    clear0 = 1'b0;
    tick();
    checks++;
    if (b0.PC_Out !== 32'h4) begin
      failures++;
      $display("FAIL mid_seq1 got=%h exp=%h", b0.PC_Out, 32'h4);
    end
    tick();
    checks++;
    if (b0.PC_Out !== 32'h8) begin
      failures++;
      $display("FAIL mid_seq2 got=%h exp=%h", b0.PC_Out, 32'h8);
    end
    redirect0(32'h40);
    checks++;
    if (b0.pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL mid_btbclr got=%b exp=0", b0.pred_taken);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    clear1 = 1'b1;
    test_reset();
    test_wrap();
    test_priority();
    test_btb();
    test_alias();
    test_stall();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
